// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the legal range of the WIDTH parameter.
package serial_sub_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 16;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: diff = x - y - bin, with borrow out.
module full_subtractor_bit (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bout
);

   // Borrow is generated when y > x, or propagated when x == y.
   always_comb begin
      diff = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor d = a - b, one bit per clock, LSB
// first, with a start/done handshake.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("serial_subtractor: WIDTH out of legal range 2..16");
   end

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             br;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   // Holds the low WIDTH-1 result bits; the final bit goes straight into d.
   logic [WIDTH-2:0] res;
   logic             cell_diff;
   logic             cell_bout;
   logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb;
   logic             b_msb;
`endif

   full_subtractor_bit u_cell (
      .x    (sh_a[0]),
      .y    (sh_b[0]),
      .bin  (br),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));

   // Operand and partial-result shift registers (datapath, no reset needed).
   always_ff @(posedge clk) begin
      if (state == S_IDLE && start) begin
         sh_a <= a;
         sh_b <= b;
`ifdef SERIAL_SUB_OVF_EN
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
`endif
      end else if (state == S_RUN) begin
         sh_a <= sh_a >> 1;
         sh_b <= sh_b >> 1;
         res  <= (res >> 1) | ((WIDTH-1)'(cell_diff) << (WIDTH - 2));
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         d     <= '0;
         bout  <= 1'b0;
         cnt   <= '0;
         br    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= S_RUN;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  br    <= 1'b0;
               end
            end
            S_RUN: begin
               br <= cell_bout;
               if (last_bit) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  cnt   <= '0;
                  d     <= {cell_diff, res};
                  bout  <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                  ovf   <= (a_msb != b_msb) && (cell_diff != a_msb);
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) against an arithmetic
// reference model. Define SERIAL_SUB_OVF_EN to also exercise ovf.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;
   logic         ovf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

`ifndef SERIAL_SUB_OVF_EN
   assign ovf = 1'b0;
`endif

   // Reference model: plain integer arithmetic.
   function automatic logic [W-1:0] model_d(input int ua, input int ub);
      return W'((ua - ub + (1 << W)) % (1 << W));
   endfunction

   function automatic logic model_bout(input int ua, input int ub);
      return (ua < ub);
   endfunction

   function automatic logic model_ovf(input int ua, input int ub);
      int sa, sb, diff;
      sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
      sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
      diff = sa - sb;
      return (diff > (1 << (W-1)) - 1) || (diff < -(1 << (W-1)));
   endfunction

   // Launch one operation and observe it; optionally pulse start with other
   // operands at observation index inj (index 0 = just after the start edge).
   task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input int inj, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         output logic [W-1:0] rd, output logic rb, output logic ro,
                         output int dcnt, output int didx, output int bcnt,
                         output logic early);
      logic [W-1:0] prev_d;
      prev_d = d;
      a = oa; b = ob; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom);
      rd = '0; rb = 1'b0; ro = 1'b0;
      dcnt = 0; didx = -1; bcnt = 0; early = 1'b0;
      for (int i = 0; i < 2*W + 6; i++) begin
         if (busy) bcnt++;
         if (i < W && d !== prev_d) early = 1'b1;
         if (done) begin
            dcnt++;
            if (didx < 0) begin
               didx = i; rd = d; rb = bout; ro = ovf;
            end
         end
         if (i == inj) begin
            start = 1'b1; a = ia; b = ib;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      total++;
      if ({busy, done, d, bout, ovf} !== '0) begin
         bad++;
         $display("FAIL reset_state: got busy=%b done=%b d=%h bout=%b ovf=%b, want all 0",
                  busy, done, d, bout, ovf);
      end
   endtask

   task automatic test_directed;
      logic [W-1:0] ta [5] = '{4'b1001, 4'b0011, 4'b1100, 4'b0000, 4'b0101};
      logic [W-1:0] tb_ [5] = '{4'b1100, 4'b1010, 4'b1001, 4'b0000, 4'b0101};
      logic [W-1:0] want_d [5] = '{4'b1101, 4'b1001, 4'b0011, 4'b0000, 4'b0000};
      logic want_b [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [W-1:0] rd;
      logic rb, ro, early;
      int dcnt, didx, bcnt;
      for (int k = 0; k < 5; k++) begin
         run_op(ta[k], tb_[k], -1, '0, '0, rd, rb, ro, dcnt, didx, bcnt, early);
         total++;
         if (rd !== want_d[k] || rb !== want_b[k]) begin
            bad++;
            $display("FAIL directed_%0d: got d=%b bout=%b, want d=%b bout=%b",
                     k, rd, rb, want_d[k], want_b[k]);
         end
         total++;
         if (didx !== W || dcnt !== 1) begin
            bad++;
            $display("FAIL directed_latency_%0d: got done idx=%0d count=%0d, want idx=%0d count=1",
                     k, didx, dcnt, W);
         end
         total++;
         if (bcnt !== W + 1) begin
            bad++;
            $display("FAIL directed_busy_%0d: got busy cycles=%0d, want %0d", k, bcnt, W + 1);
         end
      end
   endtask

   task automatic test_random;
      logic [W-1:0] oa, ob, rd;
      logic rb, ro, early;
      int dcnt, didx, bcnt;
      for (int k = 0; k < 24; k++) begin
         oa = W'($urandom); ob = W'($urandom);
         run_op(oa, ob, -1, '0, '0, rd, rb, ro, dcnt, didx, bcnt, early);
         total++;
         if (rd !== model_d(oa, ob) || rb !== model_bout(oa, ob)) begin
            bad++;
            $display("FAIL random_%0d a=%h b=%h: got d=%h bout=%b, want d=%h bout=%b",
                     k, oa, ob, rd, rb, model_d(oa, ob), model_bout(oa, ob));
         end
`ifdef SERIAL_SUB_OVF_EN
         total++;
         if (ro !== model_ovf(oa, ob)) begin
            bad++;
            $display("FAIL random_ovf_%0d a=%h b=%h: got ovf=%b, want %b",
                     k, oa, ob, ro, model_ovf(oa, ob));
         end
`endif
         total++;
         if (d !== model_d(oa, ob) || bout !== model_bout(oa, ob) || early !== 1'b0) begin
            bad++;
            $display("FAIL random_hold_%0d: got d=%h bout=%b early_change=%b, want d=%h bout=%b early_change=0",
                     k, d, bout, early, model_d(oa, ob), model_bout(oa, ob));
         end
         total++;
         if (didx !== W || dcnt !== 1 || bcnt !== W + 1) begin
            bad++;
            $display("FAIL random_timing_%0d: got idx=%0d dones=%0d busy=%0d, want idx=%0d dones=1 busy=%0d",
                     k, didx, dcnt, bcnt, W, W + 1);
         end
      end
   endtask

   task automatic test_start_ignored;
      logic [W-1:0] rd;
      logic rb, ro, early;
      int dcnt, didx, bcnt;
      run_op(4'b1001, 4'b1100, 2, 4'b0001, 4'b0111, rd, rb, ro, dcnt, didx, bcnt, early);
      total++;
      if (rd !== 4'b1101 || rb !== 1'b1 || dcnt !== 1) begin
         bad++;
         $display("FAIL start_ignored: got d=%b bout=%b dones=%0d, want d=1101 bout=1 dones=1",
                  rd, rb, dcnt);
      end
   endtask

   task automatic test_reset_mid;
      logic [W-1:0] rd;
      logic rb, ro, early;
      int dcnt, didx, bcnt, seen;
      // Leave a nonzero result behind so the reset clearing d is visible.
      run_op(4'b1001, 4'b1100, -1, '0, '0, rd, rb, ro, dcnt, didx, bcnt, early);
      a = 4'b0011; b = 4'b1010; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (busy !== 1'b0 || d !== '0 || bout !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: got busy=%b done=%b d=%b bout=%b ovf=%b, want all 0",
                  busy, done, d, bout, ovf);
      end
      seen = 0;
      for (int i = 0; i < 2*W; i++) begin
         if (done || busy) seen++;
         @(posedge clk); #1;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL reset_mid_quiet: got %0d active cycles after abort, want 0", seen);
      end
      run_op(4'b0101, 4'b0001, -1, '0, '0, rd, rb, ro, dcnt, didx, bcnt, early);
      total++;
      if (rd !== 4'b0100 || rb !== 1'b0 || dcnt !== 1) begin
         bad++;
         $display("FAIL reset_mid_recover: got d=%b bout=%b dones=%0d, want d=0100 bout=0 dones=1",
                  rd, rb, dcnt);
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] oa, ob;
      int last_done, ops, guard;
      oa = W'($urandom); ob = W'($urandom);
      a = oa; b = ob; start = 1'b1;
      last_done = -1; ops = 0; guard = 0;
      while (ops < 5 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
         if (done) begin
            total++;
            if (d !== model_d(oa, ob) || bout !== model_bout(oa, ob)) begin
               bad++;
               $display("FAIL b2b_result_%0d a=%h b=%h: got d=%h bout=%b, want d=%h bout=%b",
                        ops, oa, ob, d, bout, model_d(oa, ob), model_bout(oa, ob));
            end
            if (last_done >= 0) begin
               total++;
               if (guard - last_done !== W + 2) begin
                  bad++;
                  $display("FAIL b2b_period_%0d: got %0d cycles, want %0d",
                           ops, guard - last_done, W + 2);
               end
            end
            last_done = guard;
            ops++;
            oa = W'($urandom); ob = W'($urandom);
            a = oa; b = ob;
         end
      end
      start = 1'b0;
      total++;
      if (ops !== 5) begin
         bad++;
         $display("FAIL b2b_timeout: got %0d operations, want 5", ops);
      end
      repeat (W + 3) @(posedge clk);
      #1;
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic test_ovf;
      logic [W-1:0] rd;
      logic rb, ro, early;
      int dcnt, didx, bcnt;
      run_op(4'b0111, 4'b1000, -1, '0, '0, rd, rb, ro, dcnt, didx, bcnt, early);
      total++;
      if (rd !== 4'b1111 || rb !== 1'b1 || ro !== 1'b1) begin
         bad++;
         $display("FAIL ovf_set: got d=%b bout=%b ovf=%b, want d=1111 bout=1 ovf=1", rd, rb, ro);
      end
      total++;
      if (ovf !== 1'b1) begin
         bad++;
         $display("FAIL ovf_hold: got ovf=%b, want 1", ovf);
      end
      run_op(4'b0101, 4'b0011, -1, '0, '0, rd, rb, ro, dcnt, didx, bcnt, early);
      total++;
      if (ro !== 1'b0 || rd !== 4'b0010) begin
         bad++;
         $display("FAIL ovf_clear: got d=%b ovf=%b, want d=0010 ovf=0", rd, ro);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_start_ignored;
      test_reset_mid;
      test_back_to_back;
`ifdef SERIAL_SUB_OVF_EN
      test_ovf;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
